// File: rtl/protobuf_pkg.sv
// Shared protobuf wire-format definitions: wire types, beat kinds, decoder states
// and the key-slicing constants used by the stream decoder.
package protobuf_pkg;

  localparam int MAX_VARINT_BYTES = 10;
  // A key is {field_number, wire_type[2:0]}
  localparam int SLICE_WIRE_TYPE = 3;
  localparam int SLICE_FIELD_NUM = 3;

  typedef enum logic [2:0] {
    WT_VARINT = 3'd0,
    WT_FIX64  = 3'd1,
    WT_LEN    = 3'd2,
    WT_SGROUP = 3'd3,
    WT_EGROUP = 3'd4,
    WT_FIX32  = 3'd5,
    WT_RSV6   = 3'd6,
    WT_RSV7   = 3'd7
  } wire_type_e;

  typedef enum logic [1:0] {
    BEAT_SCALAR    = 2'd0,
    BEAT_BYTE      = 2'd1,
    BEAT_MSG_START = 2'd2,
    BEAT_MSG_END   = 2'd3
  } beat_kind_e;

  typedef enum logic [3:0] {
    ST_KEY,
    ST_VARINT,
    ST_FIX32,
    ST_FIX64,
    ST_LEN,
    ST_PAYLOAD,
    ST_PACKED,
    ST_EMIT_END,
    ST_ERROR
  } dec_state_e;

  // Groups (3/4) are deprecated and 6/7 are reserved.
  function automatic logic wt_legal(input logic [2:0] wt);
    return (wt == WT_VARINT) || (wt == WT_FIX64) || (wt == WT_LEN) || (wt == WT_FIX32);
  endfunction

endpackage

// File: rtl/proto_varint_accum.sv
// Little-endian base-128 varint accumulator shared by key, length and value decoding.
// value_o already includes the byte on data_i; the accumulator self-clears on done/overflow.
module proto_varint_accum
  import protobuf_pkg::*;
#(
  parameter int MAX_BYTES = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [63:0] value_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        lost_o
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  logic [63:0]      acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lost_q;
  logic [70:0]      shifted;

  // Bits landing at 64 and above are dropped from the value but remembered in lost_o.
  assign shifted    = {64'd0, data_i[6:0]} << (7 * cnt_q);
  assign value_o    = acc_q | shifted[63:0];
  assign lost_o     = lost_q | (|shifted[70:64]);
  assign done_o     = en_i & ~data_i[7];
  assign overflow_o = en_i & data_i[7] & (cnt_q == CNT_W'(MAX_BYTES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || done_o || overflow_o) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      lost_q <= 1'b0;
    end else if (en_i) begin
      acc_q  <= value_o;
      cnt_q  <= cnt_q + 1'b1;
      lost_q <= lost_o;
    end
  end

endmodule

// File: rtl/proto_stream_decoder.sv
// Protobuf wire-format decoder: byte stream in, typed field beats out, with a
// MAX_DEPTH nested-message length stack and sticky error detection.
module proto_stream_decoder #(
  parameter int MAX_DEPTH        = 4,
  parameter int FIELD_NUM_W      = 16,
  parameter int LEN_W            = 16,
  parameter int MAX_VARINT_BYTES = protobuf_pkg::MAX_VARINT_BYTES
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [7:0]                     s_data_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  output logic [FIELD_NUM_W-1:0]         lk_field_o,
  output logic [$clog2(MAX_DEPTH+1)-1:0] lk_depth_o,
  input  logic                           lk_is_msg_i,
  input  logic                           lk_packed_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [1:0]                     m_kind_o,
  output logic [FIELD_NUM_W-1:0]         m_field_o,
  output logic [2:0]                     m_wire_type_o,
  output logic [$clog2(MAX_DEPTH+1)-1:0] m_depth_o,
  output logic [63:0]                    m_value_o,
  output logic                           m_last_o,
  output logic                           err_o
);

  import protobuf_pkg::*;

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  // Handshake: a byte moves when s_valid_i & s_ready_o at posedge; a beat moves
  // when m_valid_o & m_ready_i at posedge; m_* hold while m_valid_o & !m_ready_i.

  dec_state_e               state_q;
  logic [DEPTH_W-1:0]       depth_q;
  logic [LEN_W-1:0]         lvl_cnt_q [MAX_DEPTH];
  logic [LEN_W-1:0]         fld_cnt_q;
  logic [FIELD_NUM_W-1:0]   field_q;
  logic [2:0]               wt_q;
  logic [2:0]               fix_idx_q;
  logic [63:0]              fix_val_q;
  logic [DEPTH_W:0]         end_n_q;
  logic [DEPTH_W-1:0]       pop_n_q;
  logic                     end_sent_q;

  logic                     byte_acc;
  logic                     va_en, va_done, va_ovf, va_lost;
  logic [63:0]              va_value;
  logic [2:0]               key_wt;
  logic                     key_wide, len_wide, len_over, fld_last;
  logic [LEN_W-1:0]         len_val;
  logic [LEN_W-1:0]         top_cnt;
  logic [DEPTH_W-1:0]       n_close;
  logic [63:0]              fix_next;

  logic                     emit, fend, zmsg, go_err, do_push;
  beat_kind_e               b_kind;
  logic [63:0]              b_value;
  logic                     b_last;
  dec_state_e               nxt;

  assign s_ready_o  = !err_o && (state_q != ST_EMIT_END) && (!m_valid_o || m_ready_i);
  assign byte_acc   = s_valid_i && s_ready_o;
  assign lk_field_o = field_q;
  assign lk_depth_o = depth_q;

  assign va_en = byte_acc && ((state_q == ST_KEY) || (state_q == ST_VARINT) ||
                              (state_q == ST_LEN) || (state_q == ST_PACKED));

  proto_varint_accum #(
    .MAX_BYTES (MAX_VARINT_BYTES)
  ) u_varint (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (va_en),
    .data_i     (s_data_i),
    .value_o    (va_value),
    .done_o     (va_done),
    .overflow_o (va_ovf),
    .lost_o     (va_lost)
  );

  assign key_wt   = va_value[SLICE_WIRE_TYPE-1:0];
  assign key_wide = va_lost || ((va_value >> (FIELD_NUM_W + SLICE_FIELD_NUM)) != 64'd0);
  assign len_wide = va_lost || ((va_value >> LEN_W) != 64'd0);
  assign len_val  = va_value[LEN_W-1:0];
  assign fld_last = (fld_cnt_q == LEN_W'(1));
  assign fix_next = fix_val_q | (64'(s_data_i) << (8 * fix_idx_q));

  // Innermost open level bounds any new length; levels with one byte left close on this byte.
  always_comb begin
    top_cnt = '0;
    n_close = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DEPTH_W'(i + 1) == depth_q) top_cnt = lvl_cnt_q[i];
      if (DEPTH_W'(i) < depth_q && lvl_cnt_q[i] == LEN_W'(1)) n_close = n_close + 1'b1;
    end
  end

  assign len_over = (depth_q != '0) && (len_val > (top_cnt - LEN_W'(1)));

  always_comb begin
    emit    = 1'b0;
    b_kind  = BEAT_SCALAR;
    b_value = '0;
    b_last  = 1'b0;
    fend    = 1'b0;
    zmsg    = 1'b0;
    go_err  = 1'b0;
    do_push = 1'b0;
    nxt     = state_q;
    if (byte_acc) begin
      case (state_q)
        ST_KEY: begin
          if (va_ovf) go_err = 1'b1;
          else if (va_done) begin
            if (key_wide || !wt_legal(key_wt)) go_err = 1'b1;
            else begin
              case (key_wt)
                WT_VARINT: nxt = ST_VARINT;
                WT_FIX64:  nxt = ST_FIX64;
                WT_FIX32:  nxt = ST_FIX32;
                default:   nxt = ST_LEN;
              endcase
            end
          end
        end
        ST_VARINT: begin
          if (va_ovf) go_err = 1'b1;
          else if (va_done) begin
            emit    = 1'b1;
            b_value = va_value;
            fend    = 1'b1;
            nxt     = ST_KEY;
          end
        end
        ST_FIX32, ST_FIX64: begin
          if (fix_idx_q == ((state_q == ST_FIX32) ? 3'd3 : 3'd7)) begin
            emit    = 1'b1;
            b_value = fix_next;
            fend    = 1'b1;
            nxt     = ST_KEY;
          end
        end
        ST_LEN: begin
          if (va_ovf) go_err = 1'b1;
          else if (va_done) begin
            if (len_wide || len_over) go_err = 1'b1;
            else if (lk_is_msg_i) begin
              if (len_val == '0) begin
                // Empty message: nothing pushed, MSG_END(1) follows via EMIT_END.
                emit   = 1'b1;
                b_kind = BEAT_MSG_START;
                zmsg   = 1'b1;
                fend   = 1'b1;
                nxt    = ST_KEY;
              end else if (depth_q == DEPTH_W'(MAX_DEPTH)) go_err = 1'b1;
              else begin
                emit    = 1'b1;
                b_kind  = BEAT_MSG_START;
                do_push = 1'b1;
                nxt     = ST_KEY;
              end
            end else if (len_val == '0) begin
              fend = 1'b1;
              nxt  = ST_KEY;
            end else nxt = lk_packed_i ? ST_PACKED : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          emit    = 1'b1;
          b_kind  = BEAT_BYTE;
          b_value = 64'(s_data_i);
          b_last  = fld_last;
          if (fld_last) begin
            fend = 1'b1;
            nxt  = ST_KEY;
          end
        end
        ST_PACKED: begin
          if (va_ovf) go_err = 1'b1;
          else if (va_done) begin
            emit    = 1'b1;
            b_value = va_value;
            if (fld_last) begin
              fend = 1'b1;
              nxt  = ST_KEY;
            end
          end else if (fld_last) go_err = 1'b1;
        end
        default: ;
      endcase
      // A message level may only close on the byte that completes a field.
      if (!go_err && n_close != '0 && !fend) go_err = 1'b1;
      if (go_err) begin
        emit    = 1'b0;
        do_push = 1'b0;
        nxt     = ST_ERROR;
      end else if (n_close != '0 || zmsg) nxt = ST_EMIT_END;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_KEY;
      depth_q       <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) lvl_cnt_q[i] <= '0;
      fld_cnt_q     <= '0;
      field_q       <= '0;
      wt_q          <= '0;
      fix_idx_q     <= '0;
      fix_val_q     <= '0;
      end_n_q       <= '0;
      pop_n_q       <= '0;
      end_sent_q    <= 1'b0;
      err_o         <= 1'b0;
      m_valid_o     <= 1'b0;
      m_kind_o      <= '0;
      m_field_o     <= '0;
      m_wire_type_o <= '0;
      m_depth_o     <= '0;
      m_value_o     <= '0;
      m_last_o      <= 1'b0;
    end else begin
      if (m_valid_o && m_ready_i) m_valid_o <= 1'b0;

      if (byte_acc) begin
        state_q <= nxt;
        for (int i = 0; i < MAX_DEPTH; i++) begin
          if (DEPTH_W'(i) < depth_q) lvl_cnt_q[i] <= lvl_cnt_q[i] - 1'b1;
          else if (DEPTH_W'(i) == depth_q && do_push) lvl_cnt_q[i] <= len_val;
        end
        if (do_push) depth_q <= depth_q + 1'b1;
        if (state_q == ST_KEY && va_done) begin
          field_q <= va_value[SLICE_FIELD_NUM +: FIELD_NUM_W];
          wt_q    <= key_wt;
        end
        if (state_q == ST_FIX32 || state_q == ST_FIX64) begin
          fix_val_q <= fend ? 64'd0 : fix_next;
          fix_idx_q <= fend ? 3'd0 : fix_idx_q + 1'b1;
        end
        if (state_q == ST_LEN && va_done) fld_cnt_q <= len_val;
        else if (state_q == ST_PAYLOAD || state_q == ST_PACKED) fld_cnt_q <= fld_cnt_q - 1'b1;
        if (go_err) err_o <= 1'b1;
        if (nxt == ST_EMIT_END) begin
          end_n_q <= (DEPTH_W+1)'(n_close) + (DEPTH_W+1)'(zmsg);
          pop_n_q <= n_close;
        end
        if (emit) begin
          m_valid_o     <= 1'b1;
          m_kind_o      <= b_kind;
          m_field_o     <= field_q;
          m_wire_type_o <= wt_q;
          m_depth_o     <= depth_q;
          m_value_o     <= b_value;
          m_last_o      <= b_last;
        end
      end

      // MSG_END carries field 0 and the depth left after closing.
      if (state_q == ST_EMIT_END) begin
        if (!end_sent_q && (!m_valid_o || m_ready_i)) begin
          m_valid_o     <= 1'b1;
          m_kind_o      <= BEAT_MSG_END;
          m_field_o     <= '0;
          m_wire_type_o <= WT_LEN;
          m_depth_o     <= depth_q - pop_n_q;
          m_value_o     <= 64'(end_n_q);
          m_last_o      <= 1'b0;
          end_sent_q    <= 1'b1;
        end else if (end_sent_q && m_valid_o && m_ready_i) begin
          depth_q    <= depth_q - pop_n_q;
          state_q    <= ST_KEY;
          end_sent_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_proto_stream_decoder.sv
// Directed bench for proto_stream_decoder: hand-computed beat sequences, error cases,
// backpressure hold and reset recovery.
module tb_proto_stream_decoder;

  localparam int BEAT_W = 2 + 16 + 3 + 3 + 64 + 1;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] lk_field;
  logic [2:0]  lk_depth;
  logic        lk_is_msg;
  logic        lk_packed;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_kind;
  logic [15:0] m_field;
  logic [2:0]  m_wire_type;
  logic [2:0]  m_depth;
  logic [63:0] m_value;
  logic        m_last;
  logic        err;

  logic [31:0] msg_mask;
  logic [31:0] pk_mask;

  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] got_q[$];
  int checks = 0;
  int errors = 0;

  proto_stream_decoder dut (
    .clk_i         (clk),
    .reset_i       (rst),
    .s_data_i      (s_data),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .lk_field_o    (lk_field),
    .lk_depth_o    (lk_depth),
    .lk_is_msg_i   (lk_is_msg),
    .lk_packed_i   (lk_packed),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .m_kind_o      (m_kind),
    .m_field_o     (m_field),
    .m_wire_type_o (m_wire_type),
    .m_depth_o     (m_depth),
    .m_value_o     (m_value),
    .m_last_o      (m_last),
    .err_o         (err)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Schema: fields 4 and 6 are messages, field 5 is packed.
  assign lk_is_msg = (lk_field < 16'd32) ? msg_mask[lk_field[4:0]] : 1'b0;
  assign lk_packed = (lk_field < 16'd32) ? pk_mask[lk_field[4:0]] : 1'b0;

  // Beat monitor, sampled mid-low-phase ahead of the accepting edge
  always @(negedge clk) begin
    #2;
    if (!rst && m_valid && m_ready)
      got_q.push_back({m_kind, m_field, m_wire_type, m_depth, m_value, m_last});
  end

  function automatic logic [BEAT_W-1:0] mk(input logic [1:0] k, input logic [15:0] f,
                                           input logic [2:0] wt, input logic [2:0] d,
                                           input logic [63:0] v, input logic l);
    return {k, f, wt, d, v, l};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: called on a negedge, returns on a negedge.
  task automatic send_byte(input logic [7:0] b, input bit expect_ok);
    int n;
    bit ok;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    #1;
    while (!s_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = s_ready;
    @(negedge clk);
    s_valid = 1'b0;
    chk($sformatf("accept_%02h", b), 128'(ok), 128'(expect_ok));
  endtask

  task automatic tx(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Scoreboard compare of collected beats against the expected queue
  task automatic check_beats(input string tag);
    repeat (6) @(negedge clk);
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s[%0d]", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    m_ready  = 1'b1;
    msg_mask = 32'h0000_0050;
    pk_mask  = 32'h0000_0020;
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_s_ready", 128'(s_ready), 128'(1));
    chk("rst_m_data", 128'({m_kind, m_field, m_wire_type, m_depth, m_value, m_last}), 128'(0));
    chk("rst_lk_depth", 128'(lk_depth), 128'(0));
    @(negedge clk);

    // 08 96 01 -> SCALAR f1 = 150
    tx(8'h08); tx(8'h96); tx(8'h01);
    exp_q.push_back(mk(2'd0, 16'd1, 3'd0, 3'd0, 64'd150, 1'b0));
    check_beats("varint150");

    // Plain bytes field 3
    tx(8'h1A); tx(8'h03); tx(8'h41); tx(8'h42); tx(8'h43);
    exp_q.push_back(mk(2'd1, 16'd3, 3'd2, 3'd0, 64'h41, 1'b0));
    exp_q.push_back(mk(2'd1, 16'd3, 3'd2, 3'd0, 64'h42, 1'b0));
    exp_q.push_back(mk(2'd1, 16'd3, 3'd2, 3'd0, 64'h43, 1'b1));
    check_beats("bytes");

    // Embedded message field 4 with two varints
    tx(8'h22); tx(8'h04); tx(8'h08); tx(8'h01); tx(8'h10); tx(8'h02);
    exp_q.push_back(mk(2'd2, 16'd4, 3'd2, 3'd0, 64'd0, 1'b0));
    exp_q.push_back(mk(2'd0, 16'd1, 3'd0, 3'd1, 64'd1, 1'b0));
    exp_q.push_back(mk(2'd0, 16'd2, 3'd0, 3'd1, 64'd2, 1'b0));
    exp_q.push_back(mk(2'd3, 16'd0, 3'd2, 3'd0, 64'd1, 1'b0));
    check_beats("msg1");
    #1; chk("msg1_depth_back", 128'(lk_depth), 128'(0)); @(negedge clk);

    // Two levels closing on the same byte -> MSG_END(2)
    tx(8'h22); tx(8'h04); tx(8'h32); tx(8'h02); tx(8'h08); tx(8'h07);
    exp_q.push_back(mk(2'd2, 16'd4, 3'd2, 3'd0, 64'd0, 1'b0));
    exp_q.push_back(mk(2'd2, 16'd6, 3'd2, 3'd1, 64'd0, 1'b0));
    exp_q.push_back(mk(2'd0, 16'd1, 3'd0, 3'd2, 64'd7, 1'b0));
    exp_q.push_back(mk(2'd3, 16'd0, 3'd2, 3'd0, 64'd2, 1'b0));
    check_beats("nested");

    // Zero-length message
    tx(8'h22); tx(8'h00);
    exp_q.push_back(mk(2'd2, 16'd4, 3'd2, 3'd0, 64'd0, 1'b0));
    exp_q.push_back(mk(2'd3, 16'd0, 3'd2, 3'd0, 64'd1, 1'b0));
    check_beats("empty_msg");

    // fixed32, fixed64, two-byte key (field 20)
    tx(8'h0D); tx(8'h78); tx(8'h56); tx(8'h34); tx(8'h12);
    tx(8'h11);
    for (int i = 1; i <= 8; i++) tx(8'(i));
    tx(8'hA0); tx(8'h01); tx(8'h05);
    exp_q.push_back(mk(2'd0, 16'd1, 3'd5, 3'd0, 64'h1234_5678, 1'b0));
    exp_q.push_back(mk(2'd0, 16'd2, 3'd1, 3'd0, 64'h0807_0605_0403_0201, 1'b0));
    exp_q.push_back(mk(2'd0, 16'd20, 3'd0, 3'd0, 64'd5, 1'b0));
    check_beats("fixed_key");

    // Packed varints with 5 cycles of backpressure on the first element
    m_ready = 1'b0;
    tx(8'h2A); tx(8'h03); tx(8'h01);
    repeat (5) begin
      #1;
      chk("hold_valid", 128'(m_valid), 128'(1));
      chk("hold_beat", 128'({m_kind, m_field, m_wire_type, m_depth, m_value, m_last}),
          128'(mk(2'd0, 16'd5, 3'd2, 3'd0, 64'd1, 1'b0)));
      chk("hold_s_ready", 128'(s_ready), 128'(0));
      @(negedge clk);
    end
    m_ready = 1'b1;
    tx(8'hAC); tx(8'h02);
    exp_q.push_back(mk(2'd0, 16'd5, 3'd2, 3'd0, 64'd1, 1'b0));
    exp_q.push_back(mk(2'd0, 16'd5, 3'd2, 3'd0, 64'd300, 1'b0));
    check_beats("packed");

    // Wire type 3 -> error
    tx(8'h0B);
    #1;
    chk("wt3_err", 128'(err), 128'(1));
    chk("wt3_s_ready", 128'(s_ready), 128'(0));
    @(negedge clk);
    check_beats("wt3");
    do_reset();

    // Varint of MAX_VARINT_BYTES continuation bytes
    tx(8'h08);
    repeat (9) tx(8'hFF);
    #1; chk("vmax9_err", 128'(err), 128'(0)); @(negedge clk);
    tx(8'hFF);
    #1; chk("vmax10_err", 128'(err), 128'(1)); @(negedge clk);
    send_byte(8'hFF, 1'b0);
    check_beats("vmax");
    do_reset();

    // Push at MAX_DEPTH
    tx(8'h22); tx(8'h09); tx(8'h22); tx(8'h07); tx(8'h22); tx(8'h05);
    tx(8'h22); tx(8'h03); tx(8'h22); tx(8'h01);
    #1; chk("maxdepth_err", 128'(err), 128'(1)); @(negedge clk);
    for (int d = 0; d < 4; d++) exp_q.push_back(mk(2'd2, 16'd4, 3'd2, 3'(d), 64'd0, 1'b0));
    check_beats("maxdepth");
    do_reset();

    // Child length larger than parent's remaining bytes
    tx(8'h22); tx(8'h02); tx(8'h1A); tx(8'h05);
    #1; chk("overlen_err", 128'(err), 128'(1)); @(negedge clk);
    exp_q.push_back(mk(2'd2, 16'd4, 3'd2, 3'd0, 64'd0, 1'b0));
    check_beats("overlen");
    do_reset();

    // Packed byte count ending inside an element
    tx(8'h2A); tx(8'h01); tx(8'hAC);
    #1; chk("pkcut_err", 128'(err), 128'(1)); @(negedge clk);
    check_beats("pkcut");
    do_reset();

    // Reset in the middle of a nested message
    tx(8'h22); tx(8'h04); tx(8'h08);
    do_reset();
    #1;
    chk("midrst_depth", 128'(lk_depth), 128'(0));
    chk("midrst_valid", 128'(m_valid), 128'(0));
    chk("midrst_err", 128'(err), 128'(0));
    @(negedge clk);
    tx(8'h08); tx(8'h96); tx(8'h01);
    exp_q.push_back(mk(2'd0, 16'd1, 3'd0, 3'd0, 64'd150, 1'b0));
    check_beats("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
